// File: rtl/csr_spmv_pkg.sv
// Shared constants for the CSR sparse-matrix x dense-vector engine: FSM encodings,
// default widths and the output clamp helper.
package csr_spmv_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_LOAD  = 2'd0;
  localparam state_t S_RUN   = 2'd1;
  localparam state_t S_DRAIN = 2'd2;

  localparam int DEF_N_ROWS     = 4;
  localparam int DEF_N_COLS     = 8;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ADDR_WIDTH = 16;

  // Clamp a sign-extended accumulator (up to 64 bits) to an ow-bit signed range.
  function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] v, input int ow);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (ow - 1));
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end
    return v;
  endfunction

endpackage

// File: rtl/spmv_mac_pipe.sv
// Multiply / accumulate / output stage of the SpMV engine. Every register holds
// while a presented result is not accepted downstream.
module spmv_mac_pipe import csr_spmv_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ACC_WIDTH  = 2 * DEF_DATA_WIDTH + 4,
  parameter int OUT_WIDTH  = 2 * DEF_DATA_WIDTH,
  parameter int ROW_W      = 2,
  parameter int SATURATE   = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  input  logic                         in_first,
  input  logic                         in_last,
  input  logic                         in_kill,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  input  logic signed [DATA_WIDTH-1:0] in_x,
  input  logic signed [DATA_WIDTH-1:0] in_bias,
  input  logic        [ROW_W-1:0]      in_row,
  input  logic                         out_ready,
  output logic                         stall,
  output logic                         out_valid,
  output logic signed [OUT_WIDTH-1:0]  out_data,
  output logic        [ROW_W-1:0]      out_row
);

  localparam int PW = 2 * DATA_WIDTH;

  logic signed [PW-1:0]         prod_q, prod_d;
  logic                         p_valid_q, p_valid_d;
  logic                         p_first_q, p_first_d;
  logic                         p_last_q, p_last_d;
  logic signed [DATA_WIDTH-1:0] p_bias_q, p_bias_d;
  logic        [ROW_W-1:0]      p_row_q, p_row_d;
  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic                         out_valid_q, out_valid_d;
  logic signed [OUT_WIDTH-1:0]  out_data_q, out_data_d;
  logic        [ROW_W-1:0]      out_row_q, out_row_d;

  logic signed [ACC_WIDTH-1:0]  acc_base;
  logic signed [ACC_WIDTH-1:0]  acc_sum;
  logic signed [63:0]           sat_val;
  logic signed [OUT_WIDTH-1:0]  result;

  assign stall = out_valid_q && !out_ready;

  always_comb begin
    // A row's first entry restarts the sum from its bias instead of the running total.
    acc_base = p_first_q ? ACC_WIDTH'(p_bias_q) : acc_q;
    acc_sum  = acc_base + ACC_WIDTH'(prod_q);
    sat_val  = sat_clamp(64'(acc_sum), OUT_WIDTH);
    result   = (SATURATE != 0) ? OUT_WIDTH'(sat_val) : OUT_WIDTH'(acc_sum);
  end

  always_comb begin
    prod_d      = prod_q;
    p_valid_d   = p_valid_q;
    p_first_d   = p_first_q;
    p_last_d    = p_last_q;
    p_bias_d    = p_bias_q;
    p_row_d     = p_row_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_row_d   = out_row_q;
    if (!stall) begin
      p_valid_d = in_valid;
      if (in_valid) begin
        prod_d    = in_kill ? '0 : PW'(in_data) * PW'(in_x);
        p_first_d = in_first;
        p_last_d  = in_last;
        p_bias_d  = in_bias;
        p_row_d   = in_row;
      end
      out_valid_d = p_valid_q && p_last_q;
      if (p_valid_q) begin
        acc_d = acc_sum;
        if (p_last_q) begin
          out_data_d = result;
          out_row_d  = p_row_q;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q      <= '0;
      p_valid_q   <= 1'b0;
      p_first_q   <= 1'b0;
      p_last_q    <= 1'b0;
      p_bias_q    <= '0;
      p_row_q     <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_row_q   <= '0;
    end else begin
      prod_q      <= prod_d;
      p_valid_q   <= p_valid_d;
      p_first_q   <= p_first_d;
      p_last_q    <= p_last_d;
      p_bias_q    <= p_bias_d;
      p_row_q     <= p_row_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_row_q   <= out_row_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_row   = out_row_q;

endmodule

// File: rtl/csr_spmv_engine.sv
// Streaming y = A*x + b engine: buffers dense vector x, then consumes CSR entries and
// emits one biased dot-product per row through the MAC pipeline.
module csr_spmv_engine import csr_spmv_pkg::*; #(
  parameter int N_ROWS     = DEF_N_ROWS,
  parameter int N_COLS     = DEF_N_COLS,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int ACC_WIDTH  = 2 * DATA_WIDTH + $clog2(N_COLS) + 1,
  parameter int OUT_WIDTH  = 2 * DATA_WIDTH,
  parameter int SATURATE   = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic signed [DATA_WIDTH-1:0]  vec_data,
  input  logic                          vec_valid,
  output logic                          vec_ready,
  input  logic signed [DATA_WIDTH-1:0]  csr_data,
  input  logic        [ADDR_WIDTH-1:0]  csr_col,
  input  logic                          csr_row_last,
  input  logic                          csr_row_empty,
  input  logic                          csr_valid,
  output logic                          csr_ready,
  input  logic signed [DATA_WIDTH-1:0]  bias,
  output logic signed [OUT_WIDTH-1:0]   out_data,
  output logic [$clog2(N_ROWS)-1:0]     out_row,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          done,
  output logic                          err_col_oob
);

  localparam int RW = $clog2(N_ROWS);
  localparam int CW = $clog2(N_COLS);
  localparam logic [CW-1:0] LAST_COL = CW'(N_COLS - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(N_ROWS - 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   vec_cnt_q, vec_cnt_d;
  logic [RW-1:0]   row_cnt_q, row_cnt_d;
  logic            first_q, first_d;
  logic            err_q, err_d;

  logic signed [DATA_WIDTH-1:0] vec_arr [N_COLS];

  logic vec_fire;
  logic csr_fire;
  logic stall;
  logic row_last_eff;
  logic col_oob;
  logic last_hs;
  logic signed [DATA_WIDTH-1:0] x_sel;

  assign vec_ready    = rst_n && (state_q == S_LOAD);
  assign csr_ready    = (state_q == S_RUN) && !stall;
  assign vec_fire     = vec_valid && vec_ready;
  assign csr_fire     = csr_valid && csr_ready;
  assign row_last_eff = csr_row_last || csr_row_empty;
  assign col_oob      = !csr_row_empty && (csr_col >= ADDR_WIDTH'(N_COLS));
  assign x_sel        = col_oob ? '0 : vec_arr[csr_col[CW-1:0]];
  assign last_hs      = (state_q == S_DRAIN) && out_valid && out_ready && (out_row == LAST_ROW);
  assign done         = last_hs;
  assign err_col_oob  = err_q;

  genvar gi;
  generate
    for (gi = 0; gi < N_COLS; gi++) begin : g_vec
      logic signed [DATA_WIDTH-1:0] elem_q, elem_d;

      always_comb begin
        elem_d = elem_q;
        if (vec_fire && (vec_cnt_q == CW'(gi))) begin
          elem_d = vec_data;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          elem_q <= '0;
        end else begin
          elem_q <= elem_d;
        end
      end

      assign vec_arr[gi] = elem_q;
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    vec_cnt_d = vec_cnt_q;
    row_cnt_d = row_cnt_q;
    first_d   = first_q;
    err_d     = err_q;
    case (state_q)
      S_LOAD: begin
        if (vec_fire) begin
          if (vec_cnt_q == LAST_COL) begin
            vec_cnt_d = '0;
            state_d   = S_RUN;
          end else begin
            vec_cnt_d = vec_cnt_q + 1'b1;
          end
        end
      end
      S_RUN: begin
        if (csr_fire) begin
          first_d = row_last_eff;
          if (col_oob) begin
            err_d = 1'b1;
          end
          if (row_last_eff) begin
            if (row_cnt_q == LAST_ROW) begin
              row_cnt_d = '0;
              state_d   = S_DRAIN;
            end else begin
              row_cnt_d = row_cnt_q + 1'b1;
            end
          end
        end
      end
      S_DRAIN: begin
        // The out-of-range flag spans one pass, so it is dropped on the way back to loading.
        if (last_hs) begin
          state_d = S_LOAD;
          err_d   = 1'b0;
          first_d = 1'b1;
        end
      end
      default: begin
        state_d = S_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_LOAD;
      vec_cnt_q <= '0;
      row_cnt_q <= '0;
      first_q   <= 1'b1;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      vec_cnt_q <= vec_cnt_d;
      row_cnt_q <= row_cnt_d;
      first_q   <= first_d;
      err_q     <= err_d;
    end
  end

  spmv_mac_pipe #(
    .DATA_WIDTH(DATA_WIDTH),
    .ACC_WIDTH (ACC_WIDTH),
    .OUT_WIDTH (OUT_WIDTH),
    .ROW_W     (RW),
    .SATURATE  (SATURATE)
  ) u_mac (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (csr_fire),
    .in_first (first_q),
    .in_last  (row_last_eff),
    .in_kill  (csr_row_empty || col_oob),
    .in_data  (csr_data),
    .in_x     (x_sel),
    .in_bias  (bias),
    .in_row   (row_cnt_q),
    .out_ready(out_ready),
    .stall    (stall),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_row  (out_row)
  );

endmodule

// File: tb/tb_csr_spmv_engine.sv
// Directed bench for csr_spmv_engine: default instance plus two 16-bit-output
// instances (clamping and wrapping) sharing the same input streams.
module tb_csr_spmv_engine;

  logic clk = 1'b0;
  logic rst_n;
  logic signed [15:0] vec_data, csr_data, bias;
  logic [15:0] csr_col;
  logic vec_valid, csr_valid, csr_row_last, csr_row_empty, out_ready;

  logic vec_ready, csr_ready, out_valid, done, err_col_oob;
  logic signed [31:0] out_data;
  logic [1:0] out_row;

  logic [6:0] s_misc, w_misc;
  logic signed [15:0] s_out_data, w_out_data;

  int n_checks = 0;
  int n_fail = 0;
  int done_cnt = 0;

  logic signed [31:0] q_data [$];
  logic [1:0]         q_row [$];
  logic signed [15:0] q_s16 [$];
  logic signed [15:0] q_w16 [$];

  always #5 clk = ~clk;

  csr_spmv_engine dut (
    .clk(clk), .rst_n(rst_n),
    .vec_data(vec_data), .vec_valid(vec_valid), .vec_ready(vec_ready),
    .csr_data(csr_data), .csr_col(csr_col), .csr_row_last(csr_row_last),
    .csr_row_empty(csr_row_empty), .csr_valid(csr_valid), .csr_ready(csr_ready),
    .bias(bias), .out_data(out_data), .out_row(out_row), .out_valid(out_valid),
    .out_ready(out_ready), .done(done), .err_col_oob(err_col_oob)
  );

  csr_spmv_engine #(.OUT_WIDTH(16), .SATURATE(1)) dut_s16 (
    .clk(clk), .rst_n(rst_n),
    .vec_data(vec_data), .vec_valid(vec_valid), .vec_ready(s_misc[0]),
    .csr_data(csr_data), .csr_col(csr_col), .csr_row_last(csr_row_last),
    .csr_row_empty(csr_row_empty), .csr_valid(csr_valid), .csr_ready(s_misc[1]),
    .bias(bias), .out_data(s_out_data), .out_row(s_misc[6:5]), .out_valid(s_misc[2]),
    .out_ready(out_ready), .done(s_misc[3]), .err_col_oob(s_misc[4])
  );

  csr_spmv_engine #(.OUT_WIDTH(16), .SATURATE(0)) dut_w16 (
    .clk(clk), .rst_n(rst_n),
    .vec_data(vec_data), .vec_valid(vec_valid), .vec_ready(w_misc[0]),
    .csr_data(csr_data), .csr_col(csr_col), .csr_row_last(csr_row_last),
    .csr_row_empty(csr_row_empty), .csr_valid(csr_valid), .csr_ready(w_misc[1]),
    .bias(bias), .out_data(w_out_data), .out_row(w_misc[6:5]), .out_valid(w_misc[2]),
    .out_ready(out_ready), .done(w_misc[3]), .err_col_oob(w_misc[4])
  );

  // Record every handshaken result and every done pulse.
  always @(posedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      q_data.push_back(out_data);
      q_row.push_back(out_row);
      q_s16.push_back(s_out_data);
      q_w16.push_back(w_out_data);
    end
    if (rst_n && done) done_cnt <= done_cnt + 1;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_queues;
    q_data.delete(); q_row.delete(); q_s16.delete(); q_w16.delete();
  endtask

  task automatic load_vec(input logic signed [15:0] xv [8]);
    bit ok;
    for (int i = 0; i < 8; i++) begin
      vec_data = xv[i];
      vec_valid = 1'b1;
      ok = 1'b0;
      for (int k = 0; k < 50; k++) begin
        @(negedge clk);
        if (vec_ready) begin ok = 1'b1; break; end
      end
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL vec_handshake elem %0d got no vec_ready, required 1", i); end
      tick();
    end
    vec_valid = 1'b0;
  endtask

  task automatic put_entry(input logic signed [15:0] d, input logic [15:0] c,
                           input logic last, input logic empty, input logic signed [15:0] b);
    bit ok;
    csr_data = d; csr_col = c; csr_row_last = last; csr_row_empty = empty; bias = b;
    csr_valid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (csr_ready) begin ok = 1'b1; break; end
    end
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL csr_handshake col %0d got no csr_ready, required 1", c); end
    tick();
    csr_valid = 1'b0; csr_row_last = 1'b0; csr_row_empty = 1'b0;
  endtask

  task automatic wait_results(input int n);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (q_data.size() >= n) begin ok = 1'b1; break; end
      tick();
    end
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL result_wait got %0d results, required %0d", q_data.size(), n); end
    tick(); tick();
  endtask

  task automatic test_reset;
    rst_n = 1'b0; vec_valid = 0; csr_valid = 0; csr_row_last = 0; csr_row_empty = 0;
    vec_data = 0; csr_data = 0; csr_col = 0; bias = 0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({vec_ready, csr_ready, out_valid, done, err_col_oob} !== 5'b0)
      begin n_fail++; $display("FAIL reset_ctrl got %b, required 00000", {vec_ready, csr_ready, out_valid, done, err_col_oob}); end
    n_checks++;
    if (out_data !== 32'sd0 || out_row !== 2'd0)
      begin n_fail++; $display("FAIL reset_data got data %0d row %0d, required 0/0", out_data, out_row); end
    tick();
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (vec_ready !== 1'b1 || csr_ready !== 1'b0)
      begin n_fail++; $display("FAIL reset_release got vec_ready %b csr_ready %b, required 1/0", vec_ready, csr_ready); end
    $display("test_reset done");
  endtask

  task automatic test_basic;
    logic signed [15:0] x_inc [8] = '{1, 2, 3, 4, 5, 6, 7, 8};
    int exp_d [4] = '{27, 9, 5, 7};
    int d0;
    logic signed [31:0] gd;
    logic [1:0] gr;
    clear_queues();
    load_vec(x_inc);
    d0 = done_cnt;
    put_entry(16'sd2, 16'd0, 1'b0, 1'b0, 16'sd1);
    put_entry(16'sd3, 16'd7, 1'b1, 1'b0, 16'sd1);
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_latency_t1 got out_valid %b, required 0", out_valid); end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 32'sd27 || out_row !== 2'd0)
      begin n_fail++; $display("FAIL basic_latency_t2 got valid %b data %0d row %0d, required 1/27/0", out_valid, out_data, out_row); end
    tick();
    put_entry(16'sd1, 16'd1, 1'b0, 1'b0, 16'sd0);
    put_entry(16'sd1, 16'd2, 1'b0, 1'b0, 16'sd0);
    put_entry(16'sd1, 16'd3, 1'b1, 1'b0, 16'sd0);
    put_entry(-16'sd1, 16'd4, 1'b1, 1'b0, 16'sd10);
    put_entry(16'sd4, 16'd5, 1'b0, 1'b0, -16'sd3);
    put_entry(-16'sd2, 16'd6, 1'b1, 1'b0, -16'sd3);
    wait_results(4);
    n_checks++;
    if (q_data.size() != 4) begin n_fail++; $display("FAIL basic_count got %0d results, required 4", q_data.size()); end
    for (int i = 0; i < 4 && q_data.size() > 0; i++) begin
      gd = q_data.pop_front(); gr = q_row.pop_front();
      n_checks++;
      if (gd !== exp_d[i] || gr !== i)
        begin n_fail++; $display("FAIL basic_row%0d got data %0d row %0d, required %0d/%0d", i, gd, gr, exp_d[i], i); end
    end
    n_checks++;
    if (done_cnt - d0 != 1 || vec_ready !== 1'b1)
      begin n_fail++; $display("FAIL basic_done got pulses %0d vec_ready %b, required 1/1", done_cnt - d0, vec_ready); end
    $display("test_basic done");
  endtask

  task automatic test_empty_row;
    logic signed [15:0] x_inc [8] = '{1, 2, 3, 4, 5, 6, 7, 8};
    int exp_d [4] = '{-5, 1, 7, 10};
    logic signed [31:0] gd;
    logic [1:0] gr;
    clear_queues();
    load_vec(x_inc);
    put_entry(16'sd99, 16'd0, 1'b0, 1'b1, -16'sd5);
    put_entry(16'sd1, 16'd0, 1'b1, 1'b0, 16'sd0);
    put_entry(16'sd100, 16'd12, 1'b0, 1'b1, 16'sd7);
    n_checks++;
    if (err_col_oob !== 1'b0) begin n_fail++; $display("FAIL empty_no_oob got err %b, required 0", err_col_oob); end
    put_entry(16'sd5, 16'd2, 1'b1, 1'b0, -16'sd5);
    wait_results(4);
    for (int i = 0; i < 4 && q_data.size() > 0; i++) begin
      gd = q_data.pop_front(); gr = q_row.pop_front();
      n_checks++;
      if (gd !== exp_d[i] || gr !== i)
        begin n_fail++; $display("FAIL empty_row%0d got data %0d row %0d, required %0d/%0d", i, gd, gr, exp_d[i], i); end
    end
    $display("test_empty_row done");
  endtask

  task automatic test_saturate;
    logic signed [15:0] x_max [8] = '{32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767};
    int exp_d [4] = '{32'sh7FFFFFFF, 32'sh80000000, 1, -1};
    int exp_s [4] = '{32767, -32768, 1, -1};
    int exp_w [4] = '{8, 0, 1, -1};
    logic signed [31:0] gd;
    logic signed [15:0] gs, gw;
    logic [1:0] gr;
    clear_queues();
    load_vec(x_max);
    for (int i = 0; i < 8; i++) put_entry(16'sd32767, 16'(i), (i == 7), 1'b0, 16'sd0);
    for (int i = 0; i < 8; i++) put_entry(-16'sd32768, 16'(i), (i == 7), 1'b0, 16'sd0);
    @(negedge clk);
    n_checks++;
    if (s_misc !== {out_row, err_col_oob, done, out_valid, csr_ready, vec_ready} ||
        w_misc !== {out_row, err_col_oob, done, out_valid, csr_ready, vec_ready})
      begin n_fail++; $display("FAIL sat_ctrl_match got s %b w %b, required %b", s_misc, w_misc,
                               {out_row, err_col_oob, done, out_valid, csr_ready, vec_ready}); end
    tick();
    put_entry(16'sd5, 16'd0, 1'b0, 1'b1, 16'sd1);
    put_entry(16'sd5, 16'd0, 1'b0, 1'b1, -16'sd1);
    wait_results(4);
    for (int i = 0; i < 4 && q_data.size() > 0; i++) begin
      gd = q_data.pop_front(); gr = q_row.pop_front(); gs = q_s16.pop_front(); gw = q_w16.pop_front();
      n_checks++;
      if (gd !== exp_d[i] || gr !== i)
        begin n_fail++; $display("FAIL sat32_row%0d got %0d row %0d, required %0d/%0d", i, gd, gr, exp_d[i], i); end
      n_checks++;
      if (gs !== exp_s[i]) begin n_fail++; $display("FAIL sat16_row%0d got %0d, required %0d", i, gs, exp_s[i]); end
      n_checks++;
      if (gw !== exp_w[i]) begin n_fail++; $display("FAIL wrap16_row%0d got %0d, required %0d", i, gw, exp_w[i]); end
    end
    $display("test_saturate done");
  endtask

  task automatic test_backpressure;
    logic signed [15:0] x_inc [8] = '{1, 2, 3, 4, 5, 6, 7, 8};
    int exp_d [4] = '{1, 2, 9, 4};
    int d0;
    logic signed [31:0] gd;
    logic [1:0] gr;
    clear_queues();
    load_vec(x_inc);
    d0 = done_cnt;
    out_ready = 1'b0;
    put_entry(16'sd1, 16'd0, 1'b1, 1'b0, 16'sd0);
    put_entry(16'sd1, 16'd1, 1'b1, 1'b0, 16'sd0);
    csr_data = 16'sd3; csr_col = 16'd2; csr_row_last = 1'b1; bias = 16'sd0; csr_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 32'sd1 || out_row !== 2'd0 || csr_ready !== 1'b0)
        begin n_fail++; $display("FAIL stall_cycle%0d got valid %b data %0d row %0d csr_ready %b, required 1/1/0/0",
                                 c, out_valid, out_data, out_row, csr_ready); end
      tick();
    end
    out_ready = 1'b1;
    put_entry(16'sd3, 16'd2, 1'b1, 1'b0, 16'sd0);
    put_entry(16'sd1, 16'd3, 1'b1, 1'b0, 16'sd0);
    wait_results(4);
    n_checks++;
    if (q_data.size() != 4) begin n_fail++; $display("FAIL stall_count got %0d results, required 4", q_data.size()); end
    for (int i = 0; i < 4 && q_data.size() > 0; i++) begin
      gd = q_data.pop_front(); gr = q_row.pop_front();
      n_checks++;
      if (gd !== exp_d[i] || gr !== i)
        begin n_fail++; $display("FAIL stall_row%0d got data %0d row %0d, required %0d/%0d", i, gd, gr, exp_d[i], i); end
    end
    n_checks++;
    if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL stall_done got %0d pulses, required 1", done_cnt - d0); end
    $display("test_backpressure done");
  endtask

  task automatic test_col_oob;
    logic signed [15:0] x_inc [8] = '{1, 2, 3, 4, 5, 6, 7, 8};
    int exp_d [4] = '{8, 2, 0, 0};
    logic signed [31:0] gd;
    logic [1:0] gr;
    clear_queues();
    load_vec(x_inc);
    put_entry(16'sd2, 16'd1, 1'b0, 1'b0, 16'sd0);
    n_checks++;
    if (err_col_oob !== 1'b0) begin n_fail++; $display("FAIL oob_before got err %b, required 0", err_col_oob); end
    put_entry(16'sd5, 16'd9, 1'b0, 1'b0, 16'sd0);
    n_checks++;
    if (err_col_oob !== 1'b1) begin n_fail++; $display("FAIL oob_set got err %b, required 1", err_col_oob); end
    put_entry(16'sd1, 16'd3, 1'b1, 1'b0, 16'sd0);
    put_entry(16'sd7, 16'd8, 1'b1, 1'b0, 16'sd2);
    put_entry(16'sd0, 16'd0, 1'b0, 1'b1, 16'sd0);
    put_entry(16'sd0, 16'd0, 1'b0, 1'b1, 16'sd0);
    wait_results(4);
    for (int i = 0; i < 4 && q_data.size() > 0; i++) begin
      gd = q_data.pop_front(); gr = q_row.pop_front();
      n_checks++;
      if (gd !== exp_d[i] || gr !== i)
        begin n_fail++; $display("FAIL oob_row%0d got data %0d row %0d, required %0d/%0d", i, gd, gr, exp_d[i], i); end
    end
    n_checks++;
    if (err_col_oob !== 1'b0 || vec_ready !== 1'b1)
      begin n_fail++; $display("FAIL oob_clear got err %b vec_ready %b, required 0/1", err_col_oob, vec_ready); end
    $display("test_col_oob done");
  endtask

  task automatic test_reset_mid;
    logic signed [15:0] x_inc [8] = '{1, 2, 3, 4, 5, 6, 7, 8};
    logic signed [15:0] x_rev [8] = '{8, 7, 6, 5, 4, 3, 2, 1};
    int exp_d [4] = '{8, 3, 0, 36};
    int d0;
    logic signed [31:0] gd;
    logic [1:0] gr;
    clear_queues();
    load_vec(x_inc);
    out_ready = 1'b0;
    put_entry(16'sd2, 16'd0, 1'b1, 1'b0, 16'sd0);
    put_entry(16'sd5, 16'd9, 1'b0, 1'b0, 16'sd0);
    n_checks++;
    if (out_valid !== 1'b1 || err_col_oob !== 1'b1)
      begin n_fail++; $display("FAIL midrst_pre got valid %b err %b, required 1/1", out_valid, err_col_oob); end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({vec_ready, csr_ready, out_valid, done, err_col_oob} !== 5'b0 || out_data !== 32'sd0 || out_row !== 2'd0)
      begin n_fail++; $display("FAIL midrst_outputs got ctrl %b data %0d row %0d, required 00000/0/0",
                               {vec_ready, csr_ready, out_valid, done, err_col_oob}, out_data, out_row); end
    tick(); tick();
    out_ready = 1'b1;
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (vec_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_release got vec_ready %b, required 1", vec_ready); end
    clear_queues();
    d0 = done_cnt;
    load_vec(x_rev);
    put_entry(16'sd1, 16'd0, 1'b1, 1'b0, 16'sd0);
    put_entry(16'sd1, 16'd7, 1'b1, 1'b0, 16'sd2);
    put_entry(16'sd3, 16'd3, 1'b0, 1'b1, 16'sd0);
    for (int i = 0; i < 8; i++) put_entry(16'sd1, 16'(i), (i == 7), 1'b0, 16'sd0);
    wait_results(4);
    for (int i = 0; i < 4 && q_data.size() > 0; i++) begin
      gd = q_data.pop_front(); gr = q_row.pop_front();
      n_checks++;
      if (gd !== exp_d[i] || gr !== i)
        begin n_fail++; $display("FAIL rerun_row%0d got data %0d row %0d, required %0d/%0d", i, gd, gr, exp_d[i], i); end
    end
    n_checks++;
    if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL rerun_done got %0d pulses, required 1", done_cnt - d0); end
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_empty_row();
    test_saturate();
    test_backpressure();
    test_col_oob();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
